// File: rtl/hub75_row_driver.sv
// HUB75 row driver: shifts one top+bottom row pair into the panel, latches it, lights it.
// Latency: row period = 1 + N*2*CLK_DIV + 2*BLANK_TIME + 1 + on-time cycles, transfer to ready.
// Backpressure: row_ready_out is high only in IDLE; one row in flight. Optional HUB75_BRIGHTNESS_EN.

package led_display_package;
    localparam int GL_NUM_COL_PIXELS = 32;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] blue;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] red;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    localparam int GL_RGB_ROW_W = $bits(rgb_row_t);
endpackage

module hub75_row_driver
    import led_display_package::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int BLANK_TIME   = 2,
    parameter int DISPLAY_TIME = 1000
) (
    input  logic                    clk_in,
    input  logic                    n_reset_in,
    input  logic [GL_RGB_ROW_W-1:0] row_in,
    input  logic [3:0]              row_addr_in,
    input  logic                    row_valid_in,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [3:0]              brightness_in,
`endif
    output logic                    row_ready_out,
    output logic [2:0]              rgb_top_out,
    output logic [2:0]              rgb_bot_out,
    output logic                    pxl_clk_out,
    output logic                    lat_out,
    output logic                    n_oe_out,
    output logic [3:0]              addr_out
);

    localparam int N   = GL_NUM_COL_PIXELS;
    localparam int PW  = $clog2(N);
    localparam int PHW = $clog2(CLK_DIV + 1);
    localparam int CW  = $clog2(DISPLAY_TIME + 1);

    localparam logic [PW-1:0]  PIX_LAST   = PW'(N - 1);
    localparam logic [PHW-1:0] PH_LAST    = PHW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_TIME - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SHIFT      = 3'd1;
    localparam logic [2:0] ST_BLANK_PRE  = 3'd2;
    localparam logic [2:0] ST_LATCH      = 3'd3;
    localparam logic [2:0] ST_BLANK_POST = 3'd4;
    localparam logic [2:0] ST_DISPLAY    = 3'd5;

    logic [2:0]     state_q, state_d;
    rgb_row_t       row_q, row_d;
    logic [3:0]     addr_q, addr_d;
    logic [3:0]     addr_out_q, addr_out_d;
    logic [PW-1:0]  pix_q, pix_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic           hi_q, hi_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  on_last;
    logic [PW-1:0]  col;

`ifdef HUB75_BRIGHTNESS_EN
    localparam int ON_UNIT = DISPLAY_TIME >> 4;
    logic [CW-1:0] on_last_q, on_last_d;

    assign on_last = on_last_q;
`else
    assign on_last = CW'(DISPLAY_TIME - 1);
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        addr_d     = addr_q;
        addr_out_d = addr_out_q;
        pix_d      = pix_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        cnt_d      = cnt_q;
`ifdef HUB75_BRIGHTNESS_EN
        on_last_d  = on_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (row_valid_in) begin
                    row_d   = rgb_row_t'(row_in);
                    addr_d  = row_addr_in;
                    state_d = ST_SHIFT;
                    pix_d   = '0;
                    phase_d = '0;
                    hi_d    = 1'b0;
                end
            end
            ST_SHIFT: begin
                // Pixel index only advances as pxl_clk falls, so data never moves while it is high.
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    hi_d    = !hi_q;
                    if (hi_q) begin
                        if (pix_q == PIX_LAST) begin
                            state_d = ST_BLANK_PRE;
                            pix_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_BLANK_PRE: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d    = ST_LATCH;
                    cnt_d      = '0;
                    addr_out_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                state_d = ST_BLANK_POST;
                cnt_d   = '0;
`ifdef HUB75_BRIGHTNESS_EN
                on_last_d = CW'(ON_UNIT * (int'(brightness_in) + 1) - 1);
`endif
            end
            ST_BLANK_POST: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DISPLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DISPLAY: begin
                if (cnt_q == on_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            addr_q     <= '0;
            addr_out_q <= '0;
            pix_q      <= '0;
            phase_q    <= '0;
            hi_q       <= 1'b0;
            cnt_q      <= '0;
`ifdef HUB75_BRIGHTNESS_EN
            on_last_q  <= CW'(ON_UNIT * 16 - 1);
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            addr_out_q <= addr_out_d;
            pix_q      <= pix_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
`ifdef HUB75_BRIGHTNESS_EN
            on_last_q  <= on_last_d;
`endif
        end
    end

    // Column N-1 goes out first, so the pixel counter maps to the mirrored column.
    assign col = PIX_LAST - pix_q;

    always_comb begin
        rgb_top_out = 3'b000;
        rgb_bot_out = 3'b000;
        if (state_q == ST_SHIFT) begin
            rgb_top_out = {row_q.top.blue[col], row_q.top.green[col], row_q.top.red[col]};
            rgb_bot_out = {row_q.bot.blue[col], row_q.bot.green[col], row_q.bot.red[col]};
        end
    end

    assign row_ready_out = (state_q == ST_IDLE);
    assign pxl_clk_out   = (state_q == ST_SHIFT) && hi_q;
    assign lat_out       = (state_q == ST_LATCH);
    assign n_oe_out      = (state_q != ST_DISPLAY);
    assign addr_out      = addr_out_q;

endmodule

// File: tb/tb_hub75_row_driver.sv
// Scoreboard bench for hub75_row_driver: expected pixels/addresses queued at transfer, compared on output.
module tb_hub75_row_driver;
    import led_display_package::*;

    localparam int N      = GL_NUM_COL_PIXELS;
    localparam int CD     = 2;
    localparam int BT     = 2;
    localparam int DT     = 64;
    localparam int PERIOD = 1 + N * 2 * CD + 2 * BT + 1 + DT;

    logic       clk_in = 1'b0;
    logic       n_reset_in;
    rgb_row_t   row_in;
    logic [3:0] row_addr_in;
    logic       row_valid_in;
    logic       row_ready_out;
    logic [2:0] rgb_top_out, rgb_bot_out;
    logic       pxl_clk_out, lat_out, n_oe_out;
    logic [3:0] addr_out;
`ifdef HUB75_BRIGHTNESS_EN
    logic [3:0] brightness_in;
    logic [3:0] bright_after;
`endif

    hub75_row_driver #(.CLK_DIV(CD), .BLANK_TIME(BT), .DISPLAY_TIME(DT)) dut (
        .clk_in(clk_in), .n_reset_in(n_reset_in), .row_in(row_in),
        .row_addr_in(row_addr_in), .row_valid_in(row_valid_in),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness_in(brightness_in),
`endif
        .row_ready_out(row_ready_out), .rgb_top_out(rgb_top_out), .rgb_bot_out(rgb_bot_out),
        .pxl_clk_out(pxl_clk_out), .lat_out(lat_out), .n_oe_out(n_oe_out), .addr_out(addr_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];
    logic [3:0] exp_addr_q[$];

    int rises, lat_cnt, noe_low, ghost, addr_bad, ready_cyc;
    logic [3:0] lat_addr;

    task automatic push_row(input rgb_row_t r, input logic [3:0] a);
        for (int k = N - 1; k >= 0; k--)
            exp_q.push_back({r.top.blue[k], r.top.green[k], r.top.red[k],
                             r.bot.blue[k], r.bot.green[k], r.bot.red[k]});
        exp_addr_q.push_back(a);
    endtask

    function automatic rgb_row_t rand_row();
        rgb_row_t r;
        r.top.red = $urandom(); r.top.green = $urandom(); r.top.blue = $urandom();
        r.bot.red = $urandom(); r.bot.green = $urandom(); r.bot.blue = $urandom();
        return r;
    endfunction

    task automatic send(input rgb_row_t r, input logic [3:0] a);
        row_in = r;
        row_addr_in = a;
        row_valid_in = 1'b1;
        push_row(r, a);
        @(posedge clk_in);
        #1;
        row_valid_in = 1'b0;
    endtask

    // Monitor only: records what the panel pins did until ready returns (bounded).
    task automatic watch(input int perturb_at);
        logic prev_clk;
        logic [3:0] prev_addr;
        rises = 0; lat_cnt = 0; noe_low = 0; ghost = 0; addr_bad = 0; ready_cyc = -1;
        lat_addr = 4'h0;
        obs_q.delete();
        prev_clk = 1'b0;
        prev_addr = addr_out;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk_in);
            if (c == perturb_at) begin
                row_in = ~row_in;
                row_addr_in = ~row_addr_in;
            end
            if (pxl_clk_out && !prev_clk) begin
                rises++;
                obs_q.push_back({rgb_top_out, rgb_bot_out});
            end
            if (lat_out) begin
                lat_cnt++;
                lat_addr = addr_out;
            end
`ifdef HUB75_BRIGHTNESS_EN
            if (lat_cnt > 0 && !lat_out) brightness_in = bright_after;
`endif
            if (!n_oe_out) begin
                noe_low++;
                if (pxl_clk_out || lat_out) ghost++;
                if (addr_out !== prev_addr) addr_bad++;
            end
            prev_clk = pxl_clk_out;
            prev_addr = addr_out;
            if (row_ready_out) begin
                ready_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_reset_in = 1'b0;
        row_valid_in = 1'b0;
        row_in = '0;
        row_addr_in = 4'h0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        vectors++;
        if ({row_ready_out, n_oe_out, lat_out, pxl_clk_out, addr_out, rgb_top_out, rgb_bot_out} !== 14'b11_0000_0000_0000)
            begin miscompares++; $display("FAIL reset_held got %b want 11000000000000",
                {row_ready_out, n_oe_out, lat_out, pxl_clk_out, addr_out, rgb_top_out, rgb_bot_out}); end
        @(posedge clk_in);
        #1 n_reset_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            vectors++;
            if ({row_ready_out, n_oe_out, lat_out, pxl_clk_out, addr_out, rgb_top_out, rgb_bot_out} !== 14'b11_0000_0000_0000)
                begin miscompares++; $display("FAIL idle_steady[%0d] got %b want 11000000000000", i,
                    {row_ready_out, n_oe_out, lat_out, pxl_clk_out, addr_out, rgb_top_out, rgb_bot_out}); end
        end
    endtask

    task automatic test_single_row;
        rgb_row_t r;
        logic [5:0] e, o;
        r = '0;
        r.top.red = 32'h8000_0001;
        r.bot.blue = 32'h0000_0001;
        send(r, 4'd5);
        watch(0);
        vectors++; if (rises !== N) begin miscompares++; $display("FAIL single_rises got %0d want %0d", rises, N); end
        vectors++; if (obs_q.size() > 0 && obs_q[0] !== 6'b001_000) begin miscompares++; $display("FAIL single_first_px got %b want 001000", obs_q[0]); end
        vectors++; if (obs_q.size() == N && obs_q[N-1] !== 6'b001_100) begin miscompares++; $display("FAIL single_last_px got %b want 001100", obs_q[N-1]); end
        vectors++; if (lat_cnt !== 1) begin miscompares++; $display("FAIL single_lat_cnt got %0d want 1", lat_cnt); end
        vectors++; if (noe_low !== DT) begin miscompares++; $display("FAIL single_on_time got %0d want %0d", noe_low, DT); end
        vectors++; if (ready_cyc !== PERIOD) begin miscompares++; $display("FAIL single_period got %0d want %0d", ready_cyc, PERIOD); end
        vectors++; if (ghost !== 0) begin miscompares++; $display("FAIL single_ghost got %0d want 0", ghost); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++; if (o !== e) begin miscompares++; $display("FAIL single_px got %b want %b", o, e); end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_px_missing got %0d left want 0", exp_q.size()); end
        e = {2'b00, exp_addr_q.pop_front()};
        vectors++; if ({2'b00, lat_addr} !== e) begin miscompares++; $display("FAIL single_addr got %0d want %0d", lat_addr, e); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        rgb_row_t ra, rb;
        logic [5:0] e, o;
        ra = rand_row();
        rb = rand_row();
        row_in = ra; row_addr_in = 4'd3; row_valid_in = 1'b1;
        push_row(ra, 4'd3);
        @(posedge clk_in);
        #1;
        row_in = rb; row_addr_in = 4'd4;
        for (int n = 0; n < 2; n++) begin
            watch(0);
            vectors++; if (ready_cyc !== PERIOD) begin miscompares++; $display("FAIL b2b_period[%0d] got %0d want %0d", n, ready_cyc, PERIOD); end
            vectors++; if (ghost !== 0) begin miscompares++; $display("FAIL b2b_ghost[%0d] got %0d want 0", n, ghost); end
            vectors++; if (addr_bad !== 0) begin miscompares++; $display("FAIL b2b_addr_lit[%0d] got %0d want 0", n, addr_bad); end
            vectors++; if (rises !== N) begin miscompares++; $display("FAIL b2b_rises[%0d] got %0d want %0d", n, rises, N); end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                vectors++; if (o !== e) begin miscompares++; $display("FAIL b2b_px[%0d] got %b want %b", n, o, e); end
            end
            exp_q.delete();
            e = {2'b00, exp_addr_q.pop_front()};
            vectors++; if ({2'b00, lat_addr} !== e) begin miscompares++; $display("FAIL b2b_addr[%0d] got %0d want %0d", n, lat_addr, e); end
            if (n == 0) begin
                push_row(rb, 4'd4);
                @(posedge clk_in);
                #1 row_valid_in = 1'b0;
            end
        end
    endtask

    task automatic test_valid_busy;
        logic [5:0] e, o;
        send(rand_row(), 4'd7);
        watch(20);
        vectors++; if (rises !== N) begin miscompares++; $display("FAIL busy_rises got %0d want %0d", rises, N); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++; if (o !== e) begin miscompares++; $display("FAIL busy_px got %b want %b", o, e); end
        end
        exp_q.delete();
        e = {2'b00, exp_addr_q.pop_front()};
        vectors++; if ({2'b00, lat_addr} !== e) begin miscompares++; $display("FAIL busy_addr got %0d want %0d", lat_addr, e); end
    endtask

    task automatic test_reset_mid;
        logic [5:0] e, o;
        logic prev_clk;
        int seen;
        send(rand_row(), 4'd9);
        seen = 0;
        prev_clk = 1'b0;
        for (int c = 0; c < 200 && seen < 10; c++) begin
            @(negedge clk_in);
            if (pxl_clk_out && !prev_clk) seen++;
            prev_clk = pxl_clk_out;
        end
        vectors++; if (seen !== 10) begin miscompares++; $display("FAIL mid_reach_px10 got %0d want 10", seen); end
        @(negedge clk_in);
        #1 n_reset_in = 1'b0;
        #1;
        vectors++;
        if ({row_ready_out, n_oe_out, lat_out, pxl_clk_out, addr_out, rgb_top_out, rgb_bot_out} !== 14'b11_0000_0000_0000)
            begin miscompares++; $display("FAIL mid_async_reset got %b want 11000000000000",
                {row_ready_out, n_oe_out, lat_out, pxl_clk_out, addr_out, rgb_top_out, rgb_bot_out}); end
        seen = 0;
        repeat (4) begin
            @(negedge clk_in);
            if (lat_out) seen++;
        end
        @(posedge clk_in);
        #1 n_reset_in = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_in);
            if (lat_out) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL mid_no_latch got %0d want 0", seen); end
        vectors++; if (addr_out !== 4'd0) begin miscompares++; $display("FAIL mid_addr_kept got %0d want 0", addr_out); end
        exp_q.delete();
        exp_addr_q.delete();
        send(rand_row(), 4'd12);
        watch(0);
        vectors++; if (rises !== N) begin miscompares++; $display("FAIL mid_after_rises got %0d want %0d", rises, N); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++; if (o !== e) begin miscompares++; $display("FAIL mid_after_px got %b want %b", o, e); end
        end
        exp_q.delete();
        e = {2'b00, exp_addr_q.pop_front()};
        vectors++; if ({2'b00, lat_addr} !== e) begin miscompares++; $display("FAIL mid_after_addr got %0d want %0d", lat_addr, e); end
    endtask

`ifdef HUB75_BRIGHTNESS_EN
    task automatic test_brightness;
        brightness_in = 4'd0; bright_after = 4'd0;
        send(rand_row(), 4'd1);
        watch(0);
        vectors++; if (noe_low !== (DT >> 4)) begin miscompares++; $display("FAIL bright0_on got %0d want %0d", noe_low, DT >> 4); end
        brightness_in = 4'd15; bright_after = 4'd0;
        send(rand_row(), 4'd2);
        watch(0);
        vectors++; if (noe_low !== (DT >> 4) * 16) begin miscompares++; $display("FAIL bright15_hold_on got %0d want %0d", noe_low, (DT >> 4) * 16); end
        brightness_in = 4'd15; bright_after = 4'd15;
        exp_q.delete();
        exp_addr_q.delete();
    endtask
`endif

    initial begin
`ifdef HUB75_BRIGHTNESS_EN
        brightness_in = 4'd15;
        bright_after = 4'd15;
`endif
        test_reset();
        test_single_row();
        test_back_to_back();
        test_valid_busy();
        test_reset_mid();
`ifdef HUB75_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
